// File: rtl/dmem_pkg.sv
// dmem_pkg: request type and byte-merge helper shared by the data memory and its arbiter
package dmem_pkg;
  localparam int DATA_W_MAX = 64;
  localparam int ADDR_W_MAX = 32;
  localparam int BE_W = DATA_W_MAX / 8;
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_MAX-1:0] addr;
    logic [DATA_W_MAX-1:0] wdata;
    logic [BE_W-1:0]       be;
  } dmem_req_t;
  function automatic logic [DATA_W_MAX-1:0] merge_bytes(input logic [DATA_W_MAX-1:0] old_w,
                                                        input logic [DATA_W_MAX-1:0] new_w,
                                                        input logic [BE_W-1:0] be);
    logic [DATA_W_MAX-1:0] m;
    for (int b = 0; b < BE_W; b++) m[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    return m;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; search starts at the pointer and wraps upward
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr_q, ptr_d, k;
  logic found;
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    k = '0;
    for (int i = 0; i < N; i++) begin
      k = PW'((int'(ptr_q) + i) % N);
      if (!found && !rst && req_i[k]) begin
        found = 1'b1;
        gnt_o[k] = 1'b1;
        ptr_d = (k == PW'(N - 1)) ? '0 : k + PW'(1);
      end
    end
  end
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
endmodule

// File: rtl/shared_data_mem.sv
// shared_data_mem: multi-port data memory; round-robin arbitrated single-port RAM
// with byte-enabled stores and one-cycle registered responses
module shared_data_mem
  import dmem_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 2**ADDR_W,
  parameter int NUM_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] be,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [NUM_PORTS*DATA_W-1:0]   rdata
);
  localparam int NBE = DATA_W / 8;
  localparam int AW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] ram_q [DEPTH];
  dmem_req_t r;
  logic any_gnt, in_range;
  logic [AW-1:0] idx;
  logic [DATA_W-1:0] old_w, merged_w, resp_w;
  logic [NUM_PORTS-1:0] rvalid_d, rvalid_q;
  logic [NUM_PORTS*DATA_W-1:0] rdata_d, rdata_q;
  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .gnt_o (gnt)
  );
  always_comb begin
    r = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (gnt[p]) begin
        r.we    = we[p];
        r.addr  = ADDR_W_MAX'(addr[p*ADDR_W +: ADDR_W]);
        r.wdata = DATA_W_MAX'(wdata[p*DATA_W +: DATA_W]);
        r.be    = BE_W'(be[p*NBE +: NBE]);
      end
  end
  // Out-of-range accesses are acknowledged but never touch the array
  always_comb begin
    any_gnt  = |gnt;
    in_range = r.addr < ADDR_W_MAX'(DEPTH);
    idx      = AW'(r.addr);
    old_w    = in_range ? ram_q[idx] : '0;
    merged_w = DATA_W'(merge_bytes(DATA_W_MAX'(old_w), r.wdata, r.be));
    resp_w   = !in_range ? '0 : r.we ? merged_w : old_w;
    rvalid_d = gnt;
    rdata_d  = rdata_q;
    for (int p = 0; p < NUM_PORTS; p++)
      rdata_d[p*DATA_W +: DATA_W] = gnt[p] ? resp_w : rdata_q[p*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk)
    if (any_gnt && r.we && in_range) ram_q[idx] <= merged_w;
  always_ff @(posedge clk)
    if (rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  // A response still in flight when rst rises never becomes visible
  assign rvalid = rst ? '0 : rvalid_q;
  assign rdata  = rdata_q;
endmodule

// File: tb/tb_shared_data_mem.sv
// tb_shared_data_mem: directed and random checks of shared_data_mem against a behavioural model
module tb_shared_data_mem;
  localparam int NP = 2;
  localparam int DEPTH = 200;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req, we, gnt, rvalid;
  logic [15:0] addr;
  logic [31:0] wdata, rdata;
  logic [3:0] be;
  int vectors = 0;
  int miscompares = 0;
  int mptr;
  logic [15:0] mem [DEPTH];
  logic [15:0] e_rd [NP];
  logic [1:0] e_rv, e_known, e_g, obs_gnt, obs_rv;
  always #5 clk = ~clk;
  shared_data_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH), .NUM_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic setp(input int p, input logic w, input int a, input logic [15:0] d, input logic [1:0] b);
    req[p] = 1'b1;
    we[p] = w;
    addr[p*8 +: 8] = a[7:0];
    wdata[p*16 +: 16] = d;
    be[p*2 +: 2] = b;
  endtask
  // One cycle: check outputs against the model mid-cycle, advance the model, cross the edge
  task automatic step();
    int a;
    logic [15:0] m, w;
    #1;
    obs_gnt = gnt;
    obs_rv = rvalid;
    e_g = '0;
    if (!rst)
      for (int i = 0; i < NP; i++)
        if (e_g == 2'b00 && req[(mptr + i) % NP]) e_g[(mptr + i) % NP] = 1'b1;
    check("gnt", gnt, e_g);
    check("rvalid", rvalid, rst ? 2'b00 : e_rv);
    for (int p = 0; p < NP; p++)
      if (e_known[p]) check($sformatf("rdata%0d", p), rdata[p*16 +: 16], e_rd[p]);
    e_rv = e_g;
    if (rst) begin
      mptr = 0;
      e_rv = '0;
      e_known = '1;
      for (int p = 0; p < NP; p++) e_rd[p] = '0;
    end else
      for (int p = 0; p < NP; p++)
        if (e_g[p]) begin
          a = int'(addr[p*8 +: 8]);
          m = {{8{be[p*2+1]}}, {8{be[p*2]}}};
          w = wdata[p*16 +: 16];
          mptr = (p + 1) % NP;
          e_known[p] = 1'b1;
          if (a >= DEPTH) begin
            e_rd[p] = '0;
            if (we[p]) e_known[p] = 1'b0;
          end else begin
            if (we[p]) mem[a] = (mem[a] & ~m) | (w & m);
            e_rd[p] = mem[a];
          end
        end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    be = '0;
    repeat (2) @(posedge clk);
    #1;
    mptr = 0;
    e_rv = '0;
    e_g = '0;
    e_known = '1;
    for (int p = 0; p < NP; p++) e_rd[p] = '0;
    setp(0, 1'b0, 5, 16'h0, 2'b00);
    step();
    check("rst_gnt", obs_gnt, 2'b00);
    rst = 1'b0;
    req = '0;
    for (int a = 0; a < 256; a++) begin
      setp(0, 1'b1, a, 16'($urandom), 2'b11);
      step();
    end
    req = '0;
    setp(0, 1'b0, 5, 16'h0, 2'b00);
    step();
    check("ld5_gnt", obs_gnt, 2'b01);
    check("ld5_rv", rvalid, 2'b01);
    req = '0;
    setp(0, 1'b1, 16, 16'h1234, 2'b11);
    step();
    setp(0, 1'b1, 16, 16'hABCD, 2'b01);
    step();
    check("bs_rd", rdata[15:0], 16'h12CD);
    setp(0, 1'b0, 16, 16'h0, 2'b00);
    step();
    check("bs_ld", rdata[15:0], 16'h12CD);
    req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    setp(0, 1'b0, 1, 16'h0, 2'b00);
    setp(1, 1'b0, 2, 16'h0, 2'b00);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("cont_gnt%0d", k), obs_gnt, (k % 2) ? 2'b10 : 2'b01);
      check($sformatf("cont_rv%0d", k), rvalid, obs_gnt);
    end
    req = '0;
    setp(1, 1'b1, 8'h20, 16'h00FF, 2'b11);
    step();
    req = '0;
    setp(0, 1'b0, 8'h20, 16'h0, 2'b00);
    step();
    check("sl_rd", rdata[15:0], 16'h00FF);
    req = '0;
    setp(0, 1'b1, 8'hC7, 16'h5A5A, 2'b11);
    step();
    setp(0, 1'b1, 8'hC8, 16'hBEEF, 2'b11);
    step();
    check("oob_st_rv", rvalid, 2'b01);
    setp(0, 1'b0, 8'hC8, 16'h0, 2'b00);
    step();
    check("oob_ld_rv", rvalid, 2'b01);
    check("oob_ld_rd", rdata[15:0], 16'h0000);
    setp(0, 1'b0, 8'hC7, 16'h0, 2'b00);
    step();
    check("c7_ld", rdata[15:0], 16'h5A5A);
    setp(0, 1'b1, 8'hC7, 16'hFFFF, 2'b00);
    step();
    check("be0_rd", rdata[15:0], 16'h5A5A);
    setp(0, 1'b1, 8'h30, 16'hC0DE, 2'b11);
    step();
    req = '0;
    rst = 1'b1;
    step();
    check("rst_drop", obs_rv, 2'b00);
    rst = 1'b0;
    setp(0, 1'b0, 8'h30, 16'h0, 2'b00);
    setp(1, 1'b0, 8'h31, 16'h0, 2'b00);
    step();
    check("rst_ptr", obs_gnt, 2'b01);
    check("rst_ram", rdata[15:0], 16'hC0DE);
    req[0] = 1'b0;
    step();
    req = '0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NP; p++)
        if (!req[p] || e_g[p]) begin
          if ($urandom_range(0, 3) != 0)
            setp(p, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? int'($urandom_range(192, 207)) : int'($urandom_range(0, 15)),
                 16'($urandom), 2'($urandom));
          else
            req[p] = 1'b0;
        end else if ($urandom_range(0, 15) == 0)
          req[p] = 1'b0;
      step();
    end
    rst = 1'b0;
    req = '0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
